// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, no gain compensation.
// Start operands and feedback values share the 2:1 select stage in front of the working registers.
module cordic_rotator #(
   parameter int Width = 16,
   parameter int Iter  = 14
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic signed [Width-1:0] x_i,
   input  logic signed [Width-1:0] y_i,
   input  logic signed [Width-1:0] z_i,
   output logic signed [Width-1:0] x_o,
   output logic signed [Width-1:0] y_o,
   output logic signed [Width-1:0] z_o,
   output logic                    valid_o,
   output logic                    busy_o
);

   // Counter reaches Iter after the last step, so it is sized to hold Iter itself.
   localparam int CntW = $clog2(Iter + 1);

   typedef logic signed [Width-1:0] tab_t [Iter];
   typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_t;

   function automatic real atan_pow2(input int i);
      real x, term, acc;
      if (i == 0) return 0.78539816339744831;
      x    = 1.0 / (2.0 ** i);
      acc  = 0.0;
      term = x;
      for (int unsigned k = 0; k < 40; k++) begin
         if (k % 2 == 0) acc = acc + term / $itor(2 * k + 1);
         else            acc = acc - term / $itor(2 * k + 1);
         term = term * x * x;
      end
      return acc;
   endfunction

   function automatic tab_t build_atan();
      tab_t t;
      for (int unsigned i = 0; i < Iter; i++)
         t[i] = Width'($rtoi(atan_pow2(int'(i)) * (2.0 ** (Width - 3)) + 0.5));
      return t;
   endfunction

   localparam tab_t ATAN = build_atan();

   state_t                   r_state;
   logic        [CntW-1:0]   r_cnt;
   logic signed [Width-1:0]  r_x, r_y, r_z;
   logic signed [Width-1:0]  r_xo, r_yo, r_zo;
   logic                     r_valid, r_busy;

   logic                     w_neg, w_load;
   logic signed [Width-1:0]  w_xs, w_ys, w_atan;
   logic signed [Width-1:0]  w_xn, w_yn, w_zn;
   logic signed [Width-1:0]  w_xm, w_ym, w_zm;

   assign w_neg  = r_z[Width-1];
   assign w_xs   = r_x >>> r_cnt;
   assign w_ys   = r_y >>> r_cnt;
   assign w_atan = (r_cnt < CntW'(Iter)) ? ATAN[r_cnt] : '0;

   assign w_xn = w_neg ? (r_x + w_ys)   : (r_x - w_ys);
   assign w_yn = w_neg ? (r_y - w_xs)   : (r_y + w_xs);
   assign w_zn = w_neg ? (r_z + w_atan) : (r_z - w_atan);

   // Load path wins only when the controller is able to accept a new operation.
   assign w_load = (r_state != S_ROTATE) && start_i;
   assign w_xm   = w_load ? x_i : w_xn;
   assign w_ym   = w_load ? y_i : w_yn;
   assign w_zm   = w_load ? z_i : w_zn;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_xo    <= '0;
         r_yo    <= '0;
         r_zo    <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_valid <= 1'b0;
               if (start_i) begin
                  r_x     <= w_xm;
                  r_y     <= w_ym;
                  r_z     <= w_zm;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_ROTATE;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_ROTATE: begin
               r_x   <= w_xm;
               r_y   <= w_ym;
               r_z   <= w_zm;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CntW'(Iter - 1)) begin
                  r_xo    <= w_xm;
                  r_yo    <= w_ym;
                  r_zo    <= w_zm;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign x_o     = r_xo;
   assign y_o     = r_yo;
   assign z_o     = r_zo;
   assign valid_o = r_valid;
   assign busy_o  = r_busy;

endmodule
